// File: rtl/env_ctl.sv
// Envelope sequencer: free-running step divider, IDLE/ARM/RUN note FSM and a
// two-stage sample x envelope x velocity pipeline.
module env_ctl #(
    parameter int PCM_QUANT = 16,
    parameter int ENV_DIV   = 65536,
    parameter int ENV_STEPS = 3072
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        note_valid,
    input  logic [7:0]                  note_vel,
    output logic                        note_ready,
    output logic                        env_tick,
    output logic                        env_clr,
    input  logic [PCM_QUANT-2:0]        env_y,
    input  logic signed [PCM_QUANT-1:0] smp,
    input  logic                        smp_valid,
    output logic signed [PCM_QUANT-1:0] y,
    output logic                        y_valid,
    output logic                        busy
);

    localparam int DW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
    localparam int SW = (ENV_STEPS > 1) ? $clog2(ENV_STEPS) : 1;
    localparam int PW = 2 * PCM_QUANT - 1;
    localparam int MW = PCM_QUANT + 9;

    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

    state_t          state;
    logic [DW-1:0]   div;
    logic [SW-1:0]   step;
    logic [7:0]      vel_q;
    logic            accept;

    logic [PW-1:0]   p1;
    logic [7:0]      vel1;
    logic            v1;
    logic [2*PCM_QUANT-1:0] prod1;
    logic [PCM_QUANT-1:0]   p1_hi;
    logic [MW-1:0]          prod2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (div == DW'(ENV_DIV - 1)) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign env_tick = (div == DW'(ENV_DIV - 1));
    assign accept   = note_valid && note_ready;

    // Outputs are registered with the state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step       <= '0;
            vel_q      <= '0;
            env_clr    <= 1'b0;
            busy       <= 1'b0;
            note_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state      <= ARM;
                        vel_q      <= note_vel;
                        env_clr    <= 1'b1;
                        busy       <= 1'b1;
                        note_ready <= 1'b0;
                    end
                end
                ARM: begin
                    if (env_tick) begin
                        state      <= RUN;
                        step       <= '0;
                        env_clr    <= 1'b0;
                        note_ready <= 1'b1;
                    end
                end
                RUN: begin
                    // A retrigger wins over the final-step exit to IDLE.
                    if (accept) begin
                        state      <= ARM;
                        vel_q      <= note_vel;
                        env_clr    <= 1'b1;
                        note_ready <= 1'b0;
                    end else if (env_tick) begin
                        if (step == SW'(ENV_STEPS - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    env_clr    <= 1'b0;
                    busy       <= 1'b0;
                    note_ready <= 1'b1;
                end
            endcase
        end
    end

    // Operands are extended to full width so a plain product keeps correct
    // two's-complement low bits; the slices below act as floor shifts.
    assign prod1 = {{PCM_QUANT{smp[PCM_QUANT-1]}}, smp} * {{(PCM_QUANT + 1){1'b0}}, env_y};
    assign p1_hi = p1[PW-1:PCM_QUANT-1];
    assign prod2 = {{9{p1_hi[PCM_QUANT-1]}}, p1_hi} * {{PCM_QUANT{1'b0}}, 1'b0, vel1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1      <= '0;
            vel1    <= '0;
            v1      <= 1'b0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            v1      <= smp_valid;
            y_valid <= v1;
            if (smp_valid) begin
                p1   <= prod1[PW-1:0];
                vel1 <= (state == RUN) ? vel_q : 8'd0;
            end
            if (v1) begin
                y <= $signed(prod2[PCM_QUANT+7:8]);
            end
        end
    end

endmodule

// File: tb/tb_env_ctl.sv
// Randomized bench for env_ctl with small divider/length and a behavioural
// model based on ticks-remaining bookkeeping and integer floor arithmetic.
module tb_env_ctl;

    localparam int DIV   = 4;
    localparam int STEPS = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        note_valid = 1'b0;
    logic [7:0]  note_vel = 8'd0;
    logic [14:0] env_y = 15'd0;
    logic [15:0] smp = 16'd0;
    logic        smp_valid = 1'b0;
    logic        note_ready, env_tick, env_clr, y_valid, busy;
    logic [15:0] y;

    int total = 0;
    int bad = 0;

    int          m_div;
    bit          m_arm;
    int          m_left;
    logic [7:0]  m_vel;
    bit          m_v1;
    logic [15:0] m_val1;
    logic [15:0] m_y;
    bit          m_yv;

    env_ctl #(.PCM_QUANT(16), .ENV_DIV(DIV), .ENV_STEPS(STEPS)) dut (
        .clk(clk), .rst_n(rst_n),
        .note_valid(note_valid), .note_vel(note_vel), .note_ready(note_ready),
        .env_tick(env_tick), .env_clr(env_clr), .env_y(env_y),
        .smp(smp), .smp_valid(smp_valid),
        .y(y), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint floorDiv(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic logic [15:0] refY(input logic [15:0] s, input logic [14:0] ey, input logic [7:0] v);
        longint p, a, q;
        p = longint'($signed(s)) * longint'(ey);
        a = floorDiv(p, 32768);
        q = floorDiv(a * longint'(v), 256);
        return q[15:0];
    endfunction

    function automatic bit running();
        return !m_arm && m_left > 0;
    endfunction

    task automatic modelReset();
        m_div = 0; m_arm = 0; m_left = 0; m_vel = 0;
        m_v1 = 0; m_val1 = 0; m_y = 0; m_yv = 0;
    endtask

    task automatic modelStep(input bit nv, input logic [7:0] v, input bit sv,
                             input logic [15:0] s, input logic [14:0] ey);
        bit tick;
        tick = (m_div == DIV - 1);
        m_yv = m_v1;
        if (m_v1) m_y = m_val1;
        m_v1 = sv;
        if (sv) m_val1 = refY(s, ey, running() ? m_vel : 8'd0);
        if (nv && !m_arm) begin
            m_arm = 1; m_left = 0; m_vel = v;
        end else if (m_arm && tick) begin
            m_arm = 0; m_left = STEPS;
        end else if (running() && tick) begin
            m_left--;
        end
        m_div = (m_div + 1) % DIV;
    endtask

    task automatic checkAll();
        checkOutput("env_tick", env_tick, m_div == DIV - 1);
        checkOutput("env_clr", env_clr, m_arm);
        checkOutput("busy", busy, m_arm || m_left > 0);
        checkOutput("note_ready", note_ready, !m_arm);
        checkOutput("y_valid", y_valid, m_yv);
        checkOutput("y", y, m_y);
    endtask

    // Inputs belong to the cycle before the next rising edge; outputs are
    // compared on the following falling edge.
    task automatic applyStimulus(input bit nv, input logic [7:0] v, input bit sv,
                                 input logic [15:0] s, input logic [14:0] ey);
        note_valid = nv; note_vel = v; smp_valid = sv; smp = s; env_y = ey;
        modelStep(nv, v, sv, s, ey);
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic applyReset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        note_valid = 1'b0; smp_valid = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        rst_n = 1'b1;
    endtask

    function automatic bit cond(input int which);
        case (which)
            1: return running();
            2: return running() && m_div == DIV - 1 && m_left > 1;
            3: return running() && m_div == DIV - 1 && m_left == 1;
            4: return running() && m_div == 1 && m_left == STEPS - 1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic waitFor(input int which);
        int n = 0;
        while (!cond(which) && n < 100) begin
            applyStimulus(0, 8'd0, 0, 16'd0, 15'd0);
            n++;
        end
        if (!cond(which)) begin
            total++;
            bad++;
            $display("[TB] FAIL wait_%0d got=timeout exp=condition", which);
        end
    endtask

    initial begin
        int last_clr = -1;
        int first_idle = -1;
        int n_clr;
        int e;

        modelReset();
        applyReset();

        // Reference timeline: note in cycle 1, run ends after the tick of cycle 15.
        for (int c = 0; c < 18; c++) begin
            applyStimulus(c == 1, 8'd255, c == 5, 16'h4000, 15'h7FFF);
            if (env_clr) last_clr = c + 1;
            if (!busy && c + 1 > 1 && first_idle < 0) first_idle = c + 1;
            if (c + 1 == 7) begin
                checkOutput("y_pos", y, 16'h3FBF);
                checkOutput("y_pos_valid", y_valid, 1);
            end
        end
        checkOutput("clr_last_cycle", last_clr, 3);
        checkOutput("idle_cycle", first_idle, 16);

        applyStimulus(0, 8'd0, 1, 16'h8000, 15'h7FFF);
        applyStimulus(0, 8'd0, 0, 16'h0000, 15'h0000);
        checkOutput("y_idle_zero", y, 16'h0000);
        checkOutput("y_idle_valid", y_valid, 1);

        applyStimulus(1, 8'd128, 0, 16'd0, 15'd0);
        waitFor(1);
        applyStimulus(0, 8'd0, 1, 16'h8000, 15'h7FFF);
        applyStimulus(0, 8'd0, 0, 16'd0, 15'd0);
        checkOutput("y_neg_floor", y, 16'hC000);

        waitFor(4);
        applyStimulus(1, 8'd64, 0, 16'd0, 15'd0);
        checkOutput("retrig_clr", env_clr, 1);
        checkOutput("retrig_ready", note_ready, 0);
        waitFor(1);
        applyStimulus(0, 8'd0, 1, 16'h4000, 15'h7FFF);
        applyStimulus(0, 8'd0, 0, 16'd0, 15'd0);
        checkOutput("y_new_vel", y, 16'h0FFF);

        waitFor(2);
        applyStimulus(1, 8'd200, 0, 16'd0, 15'd0);
        n_clr = env_clr ? 1 : 0;
        for (int i = 0; i < DIV + 2; i++) begin
            applyStimulus(0, 8'd0, 0, 16'd0, 15'd0);
            if (env_clr) n_clr++;
        end
        checkOutput("arm_full_period", n_clr, DIV);

        waitFor(3);
        applyStimulus(1, 8'd90, 0, 16'd0, 15'd0);
        checkOutput("final_tick_busy", busy, 1);
        checkOutput("final_tick_clr", env_clr, 1);

        waitFor(1);
        applyStimulus(0, 8'd0, 1, 16'h1234, 15'h5555);
        applyReset();
        e = 0;
        do begin
            applyStimulus(0, 8'd0, 0, 16'd0, 15'd0);
            e++;
        end while (!env_tick && e < 3 * DIV);
        // Count includes the cycle in which reset was released.
        checkOutput("first_tick_after_release", e + 1, DIV);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 11) == 0, 8'($urandom),
                          $urandom_range(0, 1) == 1, 16'($urandom), 15'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
